des_round_engine: RTL and testbench

Iterative DES cipher core built around a single Feistel-round datapath. It executes all 16 DES rounds over `16/ROUNDS_PER_CYCLE` clock cycles, including the on-the-fly key schedule, and supports encrypt and decrypt modes. It applies IP and FP at its boundaries. It is the single-DES building block that the 3DES (EDE) controller instantiates three times, or reuses three times, ahead of the steganography embedder.

---
 rtl/des_pkg.sv | 206 ++++++++++++++++++++
 rtl/des_round_engine_feistel.sv | 33 +++
 rtl/des_round_engine.sv | 110 +++++++++++
 tb/tb_des_round_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES tables, permutation helpers and FSM encoding
// shared by the round datapath and the iterative engine.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Each box is stored row-major: index = {b1,b6,b2,b3,b4,b5}.
  localparam logic [3:0] SBOX [8][64] = '{
    '{4'd14, 4'd4, 4'd13, 4'd1, 4'd2, 4'd15, 4'd11, 4'd8,
      4'd3, 4'd10, 4'd6, 4'd12, 4'd5, 4'd9, 4'd0, 4'd7,
      4'd0, 4'd15, 4'd7, 4'd4, 4'd14, 4'd2, 4'd13, 4'd1,
      4'd10, 4'd6, 4'd12, 4'd11, 4'd9, 4'd5, 4'd3, 4'd8,
      4'd4, 4'd1, 4'd14, 4'd8, 4'd13, 4'd6, 4'd2, 4'd11,
      4'd15, 4'd12, 4'd9, 4'd7, 4'd3, 4'd10, 4'd5, 4'd0,
      4'd15, 4'd12, 4'd8, 4'd2, 4'd4, 4'd9, 4'd1, 4'd7,
      4'd5, 4'd11, 4'd3, 4'd14, 4'd10, 4'd0, 4'd6, 4'd13},
    '{4'd15, 4'd1, 4'd8, 4'd14, 4'd6, 4'd11, 4'd3, 4'd4,
      4'd9, 4'd7, 4'd2, 4'd13, 4'd12, 4'd0, 4'd5, 4'd10,
      4'd3, 4'd13, 4'd4, 4'd7, 4'd15, 4'd2, 4'd8, 4'd14,
      4'd12, 4'd0, 4'd1, 4'd10, 4'd6, 4'd9, 4'd11, 4'd5,
      4'd0, 4'd14, 4'd7, 4'd11, 4'd10, 4'd4, 4'd13, 4'd1,
      4'd5, 4'd8, 4'd12, 4'd6, 4'd9, 4'd3, 4'd2, 4'd15,
      4'd13, 4'd8, 4'd10, 4'd1, 4'd3, 4'd15, 4'd4, 4'd2,
      4'd11, 4'd6, 4'd7, 4'd12, 4'd0, 4'd5, 4'd14, 4'd9},
    '{4'd10, 4'd0, 4'd9, 4'd14, 4'd6, 4'd3, 4'd15, 4'd5,
      4'd1, 4'd13, 4'd12, 4'd7, 4'd11, 4'd4, 4'd2, 4'd8,
      4'd13, 4'd7, 4'd0, 4'd9, 4'd3, 4'd4, 4'd6, 4'd10,
      4'd2, 4'd8, 4'd5, 4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
      4'd13, 4'd6, 4'd4, 4'd9, 4'd8, 4'd15, 4'd3, 4'd0,
      4'd11, 4'd1, 4'd2, 4'd12, 4'd5, 4'd10, 4'd14, 4'd7,
      4'd1, 4'd10, 4'd13, 4'd0, 4'd6, 4'd9, 4'd8, 4'd7,
      4'd4, 4'd15, 4'd14, 4'd3, 4'd11, 4'd5, 4'd2, 4'd12},
    '{4'd7, 4'd13, 4'd14, 4'd3, 4'd0, 4'd6, 4'd9, 4'd10,
      4'd1, 4'd2, 4'd8, 4'd5, 4'd11, 4'd12, 4'd4, 4'd15,
      4'd13, 4'd8, 4'd11, 4'd5, 4'd6, 4'd15, 4'd0, 4'd3,
      4'd4, 4'd7, 4'd2, 4'd12, 4'd1, 4'd10, 4'd14, 4'd9,
      4'd10, 4'd6, 4'd9, 4'd0, 4'd12, 4'd11, 4'd7, 4'd13,
      4'd15, 4'd1, 4'd3, 4'd14, 4'd5, 4'd2, 4'd8, 4'd4,
      4'd3, 4'd15, 4'd0, 4'd6, 4'd10, 4'd1, 4'd13, 4'd8,
      4'd9, 4'd4, 4'd5, 4'd11, 4'd12, 4'd7, 4'd2, 4'd14},
    '{4'd2, 4'd12, 4'd4, 4'd1, 4'd7, 4'd10, 4'd11, 4'd6,
      4'd8, 4'd5, 4'd3, 4'd15, 4'd13, 4'd0, 4'd14, 4'd9,
      4'd14, 4'd11, 4'd2, 4'd12, 4'd4, 4'd7, 4'd13, 4'd1,
      4'd5, 4'd0, 4'd15, 4'd10, 4'd3, 4'd9, 4'd8, 4'd6,
      4'd4, 4'd2, 4'd1, 4'd11, 4'd10, 4'd13, 4'd7, 4'd8,
      4'd15, 4'd9, 4'd12, 4'd5, 4'd6, 4'd3, 4'd0, 4'd14,
      4'd11, 4'd8, 4'd12, 4'd7, 4'd1, 4'd14, 4'd2, 4'd13,
      4'd6, 4'd15, 4'd0, 4'd9, 4'd10, 4'd4, 4'd5, 4'd3},
    '{4'd12, 4'd1, 4'd10, 4'd15, 4'd9, 4'd2, 4'd6, 4'd8,
      4'd0, 4'd13, 4'd3, 4'd4, 4'd14, 4'd7, 4'd5, 4'd11,
      4'd10, 4'd15, 4'd4, 4'd2, 4'd7, 4'd12, 4'd9, 4'd5,
      4'd6, 4'd1, 4'd13, 4'd14, 4'd0, 4'd11, 4'd3, 4'd8,
      4'd9, 4'd14, 4'd15, 4'd5, 4'd2, 4'd8, 4'd12, 4'd3,
      4'd7, 4'd0, 4'd4, 4'd10, 4'd1, 4'd13, 4'd11, 4'd6,
      4'd4, 4'd3, 4'd2, 4'd12, 4'd9, 4'd5, 4'd15, 4'd10,
      4'd11, 4'd14, 4'd1, 4'd7, 4'd6, 4'd0, 4'd8, 4'd13},
    '{4'd4, 4'd11, 4'd2, 4'd14, 4'd15, 4'd0, 4'd8, 4'd13,
      4'd3, 4'd12, 4'd9, 4'd7, 4'd5, 4'd10, 4'd6, 4'd1,
      4'd13, 4'd0, 4'd11, 4'd7, 4'd4, 4'd9, 4'd1, 4'd10,
      4'd14, 4'd3, 4'd5, 4'd12, 4'd2, 4'd15, 4'd8, 4'd6,
      4'd1, 4'd4, 4'd11, 4'd13, 4'd12, 4'd3, 4'd7, 4'd14,
      4'd10, 4'd15, 4'd6, 4'd8, 4'd0, 4'd5, 4'd9, 4'd2,
      4'd6, 4'd11, 4'd13, 4'd8, 4'd1, 4'd4, 4'd10, 4'd7,
      4'd9, 4'd5, 4'd0, 4'd15, 4'd14, 4'd2, 4'd3, 4'd12},
    '{4'd13, 4'd2, 4'd8, 4'd4, 4'd6, 4'd15, 4'd11, 4'd1,
      4'd10, 4'd9, 4'd3, 4'd14, 4'd5, 4'd0, 4'd12, 4'd7,
      4'd1, 4'd15, 4'd13, 4'd8, 4'd10, 4'd3, 4'd7, 4'd4,
      4'd12, 4'd5, 4'd6, 4'd11, 4'd0, 4'd14, 4'd9, 4'd2,
      4'd7, 4'd11, 4'd4, 4'd1, 4'd9, 4'd12, 4'd14, 4'd2,
      4'd0, 4'd6, 4'd10, 4'd13, 4'd15, 4'd3, 4'd5, 4'd8,
      4'd2, 4'd1, 4'd14, 4'd7, 4'd4, 4'd10, 4'd8, 4'd13,
      4'd15, 4'd12, 4'd9, 4'd0, 4'd3, 4'd5, 4'd6, 4'd11}
  };

  // Decrypt round 1 uses C0/D0 unrotated, which equals C16/D16.
  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [1:64] ip_f(input logic [1:64] x);
    for (int i = 0; i < 64; i++) ip_f[i+1] = x[IP_T[i]];
  endfunction

  function automatic logic [1:64] fp_f(input logic [1:64] x);
    for (int i = 0; i < 64; i++) fp_f[i+1] = x[FP_T[i]];
  endfunction

  function automatic logic [1:48] e_f(input logic [1:32] x);
    for (int i = 0; i < 48; i++) e_f[i+1] = x[E_T[i]];
  endfunction

  function automatic logic [1:32] p_f(input logic [1:32] x);
    for (int i = 0; i < 32; i++) p_f[i+1] = x[P_T[i]];
  endfunction

  function automatic logic [1:56] pc1_f(input logic [1:64] x);
    for (int i = 0; i < 56; i++) pc1_f[i+1] = x[PC1_T[i]];
  endfunction

  function automatic logic [1:48] pc2_f(input logic [1:56] x);
    for (int i = 0; i < 48; i++) pc2_f[i+1] = x[PC2_T[i]];
  endfunction

  function automatic logic [1:32] sbox_f(input logic [1:48] x);
    logic [5:0] b;
    for (int s = 0; s < 8; s++) begin
      b = x[6*s+1 +: 6];
      sbox_f[4*s+1 +: 4] = SBOX[s][{b[5], b[0], b[4:1]}];
    end
  endfunction

  function automatic logic [1:28] rotl28(
    input logic [1:28] x,
    input logic [1:0]  s
  );
    case (s)
      2'd1:    rotl28 = {x[2:28], x[1]};
      2'd2:    rotl28 = {x[3:28], x[1:2]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [1:28] rotr28(
    input logic [1:28] x,
    input logic [1:0]  s
  );
    case (s)
      2'd1:    rotr28 = {x[28], x[1:27]};
      2'd2:    rotr28 = {x[27:28], x[1:26]};
      default: rotr28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_round_engine_feistel.sv
// One combinational DES round including its key-schedule
// rotation; chained ROUNDS_PER_CYCLE times by the engine.
module des_feistel_round
  import des_pkg::*;
(
  input  logic [1:32] l,
  input  logic [1:32] r,
  input  logic [1:28] c,
  input  logic [1:28] d,
  input  logic        decrypt,
  input  logic [3:0]  idx,
  output logic [1:32] l_nxt,
  output logic [1:32] r_nxt,
  output logic [1:28] c_nxt,
  output logic [1:28] d_nxt
);

  logic [1:48] k;

  always_comb begin
    if (decrypt) begin
      c_nxt = rotr28(c, DEC_SHIFT[idx]);
      d_nxt = rotr28(d, DEC_SHIFT[idx]);
    end else begin
      c_nxt = rotl28(c, ENC_SHIFT[idx]);
      d_nxt = rotl28(d, ENC_SHIFT[idx]);
    end
    k     = pc2_f({c_nxt, d_nxt});
    l_nxt = r;
    r_nxt = l ^ p_f(sbox_f(e_f(r) ^ k));
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative single-DES engine: IP/PC1 on accept, 16/R steps
// of R chained rounds, FP on the held result.
module des_round_engine
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:64] in_data,
  input  logic [1:64] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] out_data,
  output logic        busy
);

  localparam int RPC   = ROUNDS_PER_CYCLE;
  localparam int STEPS = 16 / RPC;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  if (!(RPC == 1 || RPC == 2 || RPC == 4 ||
        RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state;
  logic [1:32]   l, r;
  logic [1:28]   c, d;
  logic          decrypt;
  logic [SW-1:0] step;

  logic [1:32] cl [RPC+1];
  logic [1:32] cr [RPC+1];
  logic [1:28] cc [RPC+1];
  logic [1:28] cd [RPC+1];

  assign cl[0] = l;
  assign cr[0] = r;
  assign cc[0] = c;
  assign cd[0] = d;

  for (genvar j = 0; j < RPC; j++) begin : g_round
    logic [3:0] idx;
    assign idx = 4'(int'(step) * RPC + j);

    des_feistel_round u_round (
      .l       (cl[j]),
      .r       (cr[j]),
      .c       (cc[j]),
      .d       (cd[j]),
      .decrypt (decrypt),
      .idx     (idx),
      .l_nxt   (cl[j+1]),
      .r_nxt   (cr[j+1]),
      .c_nxt   (cc[j+1]),
      .d_nxt   (cd[j+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      l       <= '0;
      r       <= '0;
      c       <= '0;
      d       <= '0;
      decrypt <= 1'b0;
      step    <= '0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (in_valid) begin
            {l, r}  <= ip_f(in_data);
            {c, d}  <= pc1_f(in_key);
            decrypt <= in_decrypt;
            step    <= '0;
            state   <= S_RUN;
          end
        end
        state == S_RUN: begin
          l    <= cl[RPC];
          r    <= cr[RPC];
          c    <= cc[RPC];
          d    <= cd[RPC];
          step <= step + SW'(1);
          if (step == SW'(STEPS - 1)) state <= S_DONE;
        end
        state == S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The final swap is folded in by feeding R||L into FP.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = out_valid ? fp_f({r, l}) : '0;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed checks of des_round_engine at every legal unroll
// factor against known-answer vectors and a small DES model.
module tb_des_round_engine;
  import des_pkg::*;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] WK  = 64'h0101010101010101;
  localparam logic [63:0] WP  = 64'h95F8A5E5DD31D900;
  localparam logic [63:0] WC  = 64'h8000000000000000;
  localparam logic [63:0] K1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h23456789ABCDEF01;
  localparam logic [63:0] TP  = 64'h4E6F772069732074;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  iv, ir, ov, ordy, bz;
  logic [1:64] in_data, in_key;
  logic        in_dec;
  logic [1:64] od [5];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int mon_k = 0;
  int acc_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_round_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (iv[g]),
      .in_ready   (ir[g]),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_dec),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_data   (od[g]),
      .busy       (bz[g])
    );
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (iv[mon_k] && ir[mon_k]) acc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] des_sw(input logic [63:0] key,
                                         input logic [63:0] data,
                                         input logic dec);
    logic [63:0] x, y;
    logic [55:0] kcd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e, kk;
    logic [31:0] l, r, s32, f, t;
    logic [5:0]  b;
    int sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    for (int i = 0; i < 64; i++) x[63-i] = data[64-IP_T[i]];
    for (int i = 0; i < 56; i++) kcd[55-i] = key[64-PC1_T[i]];
    c = kcd[55:28];
    d = kcd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int m = 0; m < sh[n]; m++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      kcd = {c, d};
      for (int i = 0; i < 48; i++) ks[n][47-i] = kcd[56-PC2_T[i]];
    end
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      kk = dec ? ks[15-n] : ks[n];
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ kk;
      for (int s = 0; s < 8; s++) begin
        b = e[47-6*s -: 6];
        s32[31-4*s -: 4] = SBOX[s][{b[5], b[0], b[4:1]}];
      end
      for (int i = 0; i < 32; i++) f[31-i] = s32[32-P_T[i]];
      t = r;
      r = l ^ f;
      l = t;
    end
    y = {r, l};
    for (int i = 0; i < 64; i++) des_sw[63-i] = y[64-FP_T[i]];
  endfunction

  task automatic run(input int k, input logic [63:0] key,
                     input logic [63:0] data, input logic dec,
                     output logic [63:0] res, output int lat);
    int t;
    in_key  = key;
    in_data = data;
    in_dec  = dec;
    iv[k]   = 1'b1;
    t = 0;
    while (!ir[k] && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od[k];
  endtask

  task automatic tdes(input int k);
    logic [63:0] keys [3];
    logic [2:0]  dm;
    logic [63:0] exp, blk;
    int t;
    keys = '{K1, K2, K1};
    dm = 3'b010;
    mon_k = k;
    acc_q.delete();
    blk = TP;
    chk("model_k1", des_sw(K1, TP, 1'b0), 64'h3FA40E8A984D4815);
    in_key  = K1;
    in_data = TP;
    in_dec  = 1'b0;
    iv[k]   = 1'b1;
    for (int s = 0; s < 3; s++) begin
      exp = des_sw(keys[s], blk, dm[s]);
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (!ov[k] && t < 60);
      chk($sformatf("tdes%0d_s%0d", k, s), od[k], exp);
      blk = exp;
      if (s < 2) begin
        in_key  = keys[s+1];
        in_data = exp;
        in_dec  = dm[s+1];
      end else begin
        iv[k] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("tdes%0d_n", k), 64'(acc_q.size()), 64'd3);
    if (acc_q.size() >= 3) begin
      chk($sformatf("tdes%0d_gap1", k), 64'(acc_q[1] - acc_q[0]),
          64'((16 >> k) + 2));
      chk($sformatf("tdes%0d_gap2", k), 64'(acc_q[2] - acc_q[1]),
          64'((16 >> k) + 2));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] res, held;
    int lat, cnt;
    rst     = 1'b1;
    iv      = '1;
    ordy    = '1;
    in_data = PT;
    in_key  = KEY;
    in_dec  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir), 64'd0);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_out_data0", od[0], 64'd0);
    chk("rst_out_data4", od[4], 64'd0);
    rst = 1'b0;
    iv  = '0;
    #1;
    chk("post_rst_ready", 64'(ir), 64'h1F);
    chk("post_rst_busy", 64'(bz), 64'd0);

    for (int k = 0; k < 5; k++) begin
      run(k, KEY, PT, 1'b0, res, lat);
      chk($sformatf("enc_r%0d", 1 << k), res, CT);
      chk($sformatf("enc_lat_r%0d", 1 << k), 64'(lat), 64'(16 >> k));
      run(k, KEY, CT, 1'b1, res, lat);
      chk($sformatf("dec_r%0d", 1 << k), res, PT);
      chk($sformatf("dec_lat_r%0d", 1 << k), 64'(lat), 64'(16 >> k));
    end
    repeat (2) @(posedge clk);
    #1;

    ordy[0] = 1'b0;
    run(0, KEY, PT, 1'b0, res, lat);
    chk("bp_result", res, CT);
    chk("cd_c", 64'(g_dut[0].u_dut.c), 64'h0F0CCAAF);
    chk("cd_d", 64'(g_dut[0].u_dut.d), 64'h0556678F);
    held = res;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        iv[0]   = 1'b1;
        in_data = WP;
        in_key  = WK;
      end
      if (i == 4) iv[0] = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", i), 64'(ov[0]), 64'd1);
      chk($sformatf("bp_data%0d", i), od[0], held);
      chk($sformatf("bp_ready%0d", i), 64'(ir[0]), 64'd0);
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(ov[0]), 64'd0);
    chk("bp_release_busy", 64'(bz[0]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queue", 64'(bz[0]), 64'd0);

    run(0, WK, WP, 1'b0, res, lat);
    chk("weak_enc", res, WC);
    run(0, WK, res, 1'b0, res, lat);
    chk("weak_enc2", res, WP);
    repeat (2) @(posedge clk);
    #1;

    in_key  = KEY;
    in_data = PT;
    in_dec  = 1'b0;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("rr_started", 64'(bz[0]), 64'd1);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rr_busy", 64'(bz[0]), 64'd0);
    chk("rr_ready", 64'(ir[0]), 64'd1);
    chk("rr_valid", 64'(ov[0]), 64'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov[0]) cnt++;
    end
    chk("rr_no_out", 64'(cnt), 64'd0);
    run(0, KEY, PT, 1'b0, res, lat);
    chk("rr_fresh", res, CT);
    chk("rr_fresh_lat", 64'(lat), 64'd16);
    repeat (2) @(posedge clk);
    #1;

    tdes(0);
    tdes(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
